// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: opcodes, the decoded control word and the
// memory-stage FSM state, plus a read/write select helper.
package lc3b_types;

  typedef enum logic [3:0] {
    OP_BR   = 4'd0,
    OP_ADD  = 4'd1,
    OP_LDB  = 4'd2,
    OP_STB  = 4'd3,
    OP_JSR  = 4'd4,
    OP_AND  = 4'd5,
    OP_LDR  = 4'd6,
    OP_STR  = 4'd7,
    OP_RTI  = 4'd8,
    OP_NOT  = 4'd9,
    OP_LDI  = 4'd10,
    OP_STI  = 4'd11,
    OP_JMP  = 4'd12,
    OP_SHF  = 4'd13,
    OP_LEA  = 4'd14,
    OP_TRAP = 4'd15
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode  opcode;
    logic        is_nop;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic        indirect_enable;
  } lc3b_control_word;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    IND_PTR  = 2'd2,
    IND_DATA = 2'd3
  } mem_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;

  // {read, write}; a malformed word asserting both is treated as a read so
  // exactly one strobe is ever raised.
  function automatic logic [1:0] rw_sel(input lc3b_control_word c);
    rw_sel = {c.mem_read, c.mem_write & ~c.mem_read};
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// LC-3b MEM-stage controller: plain and indirect (LDI/STI) data-memory accesses.
// Optional feature macro: MEM_STALL_CNT_EN adds the 32-bit stall_cycles counter.
module mem_access_ctrl
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  lc3b_control_word ctrl_in,
  input  logic             valid_in,
  input  logic [15:0]      addr_in,
  input  logic [15:0]      wdata_in,
  input  logic             dmem_resp,
  input  logic [15:0]      dmem_rdata,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [15:0]      dmem_address,
  output logic [15:0]      dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  output logic             stall_out,
  output logic             done_out,
  output logic [15:0]      mdr_out
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  mem_state_t       state_r;
  lc3b_control_word ctrl_r;
  logic [15:0]      addr_r;
  logic [15:0]      wdata_r;
  logic [15:0]      ptr_r;
  logic [15:0]      mdr_r;
  logic             done_r;

  logic             start_s;
  logic             busy_s;
  logic             last_s;
  logic             final_s;
  logic             final_read_s;
  logic             stall_s;
  logic             req_rd_s;
  logic             req_wr_s;
  logic [15:0]      req_addr_s;
  logic [15:0]      req_wdata_s;
  logic [1:0]       req_be_s;
  logic [1:0]       rw_in_s;
  logic [1:0]       rw_lat_s;

  assign start_s  = valid_in & ~ctrl_in.is_nop & (ctrl_in.mem_read | ctrl_in.mem_write);
  assign rw_in_s  = rw_sel(ctrl_in);
  assign rw_lat_s = rw_sel(ctrl_r);

  // Request decode; last_s marks the access whose response retires the instruction.
  always_comb begin
    busy_s      = 1'b0;
    last_s      = 1'b0;
    req_rd_s    = 1'b0;
    req_wr_s    = 1'b0;
    req_addr_s  = 16'h0000;
    req_wdata_s = 16'h0000;
    req_be_s    = 2'b00;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          busy_s     = 1'b1;
          req_addr_s = addr_in;
          if (ctrl_in.indirect_enable) begin
            req_rd_s = 1'b1;
            req_be_s = BE_WORD;
          end else begin
            req_rd_s    = rw_in_s[1];
            req_wr_s    = rw_in_s[0];
            req_be_s    = ctrl_in.mem_byte_enable;
            req_wdata_s = wdata_in;
            last_s      = 1'b1;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      ACCESS: begin
        busy_s      = 1'b1;
        last_s      = 1'b1;
        req_addr_s  = addr_r;
        req_rd_s    = rw_lat_s[1];
        req_wr_s    = rw_lat_s[0];
        req_be_s    = ctrl_r.mem_byte_enable;
        req_wdata_s = wdata_r;
      end
      IND_PTR: begin
        busy_s     = 1'b1;
        req_addr_s = addr_r;
        req_rd_s   = 1'b1;
        req_be_s   = BE_WORD;
      end
      IND_DATA: begin
        busy_s     = 1'b1;
        last_s     = 1'b1;
        req_addr_s = ptr_r;
        req_be_s   = BE_WORD;
        if (ctrl_r.opcode == OP_STI) begin
          req_wr_s    = 1'b1;
          req_wdata_s = wdata_r;
        end else begin
          req_rd_s = 1'b1;
        end
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign final_s      = busy_s & last_s & dmem_resp;
  assign final_read_s = final_s & req_rd_s;
  assign stall_s      = busy_s & ~final_s;

  // The request is combinational so it can launch in the start cycle; rst_n
  // gating keeps every strobe low while reset is held.
  assign dmem_read        = rst_n & req_rd_s;
  assign dmem_write       = rst_n & req_wr_s;
  assign dmem_address     = rst_n ? req_addr_s  : 16'h0000;
  assign dmem_wdata       = rst_n ? req_wdata_s : 16'h0000;
  assign dmem_byte_enable = rst_n ? req_be_s    : 2'b00;
  assign stall_out        = rst_n & stall_s;
  assign done_out         = done_r;
  assign mdr_out          = mdr_r;

  // FSM with latched request context, pointer, MDR and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ctrl_r  <= '0;
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      ptr_r   <= 16'h0000;
      mdr_r   <= 16'h0000;
      done_r  <= 1'b0;
    end else begin
      done_r <= final_s;
      if (final_read_s) begin
        mdr_r <= dmem_rdata;
      end
      case (state_r)
        IDLE: begin
          if (start_s) begin
            ctrl_r  <= ctrl_in;
            addr_r  <= addr_in;
            wdata_r <= wdata_in;
            if (ctrl_in.indirect_enable) begin
              if (dmem_resp) begin
                ptr_r   <= dmem_rdata;
                state_r <= IND_DATA;
              end else begin
                state_r <= IND_PTR;
              end
            end else begin
              state_r <= dmem_resp ? IDLE : ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmem_resp) state_r <= IDLE;
        end
        IND_PTR: begin
          if (dmem_resp) begin
            ptr_r   <= dmem_rdata;
            state_r <= IND_DATA;
          end
        end
        IND_DATA: begin
          if (dmem_resp) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Free-running count of stalled cycles; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// instruction streams against a transaction-level reference model.
module tb_mem_access_ctrl;
  import lc3b_types::*;

  logic             clk = 1'b0;
  logic             rst_n;
  lc3b_control_word ctrl_in;
  logic             valid_in;
  logic [15:0]      addr_in;
  logic [15:0]      wdata_in;
  logic             dmem_resp;
  logic [15:0]      dmem_rdata;
  logic             dmem_read;
  logic             dmem_write;
  logic [15:0]      dmem_address;
  logic [15:0]      dmem_wdata;
  logic [1:0]       dmem_byte_enable;
  logic             stall_out;
  logic             done_out;
  logic [15:0]      mdr_out;
`ifdef MEM_STALL_CNT_EN
  logic [31:0]      stall_cycles;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [15:0] model_mdr = 16'h0000;
  logic        pend_done = 1'b0;
  int          exp_stall = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .stall_out(stall_out),
    .done_out(done_out), .mdr_out(mdr_out)
`ifdef MEM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // ISA-level decode of what each opcode asks of data memory.
  function automatic lc3b_control_word make_ctrl(input lc3b_opcode op, input logic [15:0] a);
    lc3b_control_word c;
    c = '0;
    c.opcode = op;
    case (op)
      OP_LDR: begin c.mem_read = 1'b1;  c.mem_byte_enable = 2'b11; c.load_regfile = 1'b1; end
      OP_STR: begin c.mem_write = 1'b1; c.mem_byte_enable = 2'b11; end
      OP_LDB: begin c.mem_read = 1'b1;  c.mem_byte_enable = a[0] ? 2'b10 : 2'b01; c.load_regfile = 1'b1; end
      OP_STB: begin c.mem_write = 1'b1; c.mem_byte_enable = a[0] ? 2'b10 : 2'b01; end
      OP_LDI: begin c.mem_read = 1'b1;  c.mem_byte_enable = 2'b11; c.indirect_enable = 1'b1; c.load_regfile = 1'b1; end
      OP_STI: begin c.mem_write = 1'b1; c.mem_byte_enable = 2'b11; c.indirect_enable = 1'b1; end
      default: c.load_regfile = 1'b1;
    endcase
    return c;
  endfunction

  // One instruction through MEM: d0/d1 are wait cycles before each response.
  task automatic run_op(input lc3b_control_word c, input logic v, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd0, input logic [15:0] rd1,
                        input int d0, input int d1, input string tag);
    logic [15:0] ea [2];
    logic        er [2];
    logic        ew [2];
    logic [1:0]  ebe [2];
    logic [15:0] erd [2];
    int          ed [2];
    int          n;
    logic        first;
    logic        lastc;
    n = (!v || c.is_nop || !(c.mem_read || c.mem_write)) ? 0 : (c.indirect_enable ? 2 : 1);
    if (n == 2) begin
      ea[0] = a;   er[0] = 1'b1; ew[0] = 1'b0; ebe[0] = 2'b11; erd[0] = rd0; ed[0] = d0;
      ea[1] = rd0; er[1] = (c.opcode == OP_LDI); ew[1] = (c.opcode == OP_STI);
      ebe[1] = 2'b11; erd[1] = rd1; ed[1] = d1;
    end else begin
      ea[0] = a; er[0] = c.mem_read; ew[0] = c.mem_write; ebe[0] = c.mem_byte_enable;
      erd[0] = rd0; ed[0] = d0;
    end
    valid_in = v; ctrl_in = c; addr_in = a; wdata_in = wd;
    first = 1'b1;
    if (n == 0) begin
      dmem_resp = 1'($urandom_range(0, 1)); dmem_rdata = 16'($urandom);
      @(negedge clk);
      checks++;
      if ({dmem_read, dmem_write, stall_out, done_out, mdr_out} !== {1'b0, 1'b0, 1'b0, pend_done, model_mdr}) begin
        errors++;
        $display("FAIL %s passthru: rd/wr/stall/done/mdr=%b%b%b%b/%h expected 00 0 %b/%h",
                 tag, dmem_read, dmem_write, stall_out, done_out, mdr_out, pend_done, model_mdr);
      end
      pend_done = 1'b0;
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j <= ed[k]; j++) begin
        lastc = (k == n - 1) && (j == ed[k]);
        dmem_resp  = (j == ed[k]);
        dmem_rdata = (j == ed[k]) ? erd[k] : 16'($urandom);
        @(negedge clk);
        checks++;
        if ({dmem_read, dmem_write, dmem_address, dmem_byte_enable} !== {er[k], ew[k], ea[k], ebe[k]}) begin
          errors++;
          $display("FAIL %s req%0d cyc%0d: rd=%b wr=%b addr=%h be=%b expected rd=%b wr=%b addr=%h be=%b",
                   tag, k, j, dmem_read, dmem_write, dmem_address, dmem_byte_enable,
                   er[k], ew[k], ea[k], ebe[k]);
        end
        if (ew[k]) begin
          checks++;
          if (dmem_wdata !== wd) begin
            errors++;
            $display("FAIL %s wdata: got %h expected %h", tag, dmem_wdata, wd);
          end
        end
        checks++;
        if ({stall_out, done_out, mdr_out} !== {!lastc, first ? pend_done : 1'b0, model_mdr}) begin
          errors++;
          $display("FAIL %s status%0d/%0d: stall=%b done=%b mdr=%h expected stall=%b done=%b mdr=%h",
                   tag, k, j, stall_out, done_out, mdr_out, !lastc, first ? pend_done : 1'b0, model_mdr);
        end
        if (!lastc) exp_stall++;
        first = 1'b0;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
      end
    end
    pend_done = 1'b1;
    if (er[n-1]) model_mdr = erd[n-1];
  endtask

  // A cycle with no memory instruction, optionally carrying a stray response.
  task automatic idle_cycle(input logic stray, input string tag);
    if ($urandom_range(0, 1) == 0) begin
      valid_in = 1'b0; ctrl_in = make_ctrl(OP_LDR, 16'h0000);
    end else begin
      valid_in = 1'b1; ctrl_in = make_ctrl(OP_ADD, 16'h0000);
    end
    dmem_resp = stray; dmem_rdata = 16'($urandom);
    @(negedge clk);
    checks++;
    if ({dmem_read, dmem_write, stall_out, done_out, mdr_out} !== {1'b0, 1'b0, 1'b0, pend_done, model_mdr}) begin
      errors++;
      $display("FAIL %s idle: rd/wr/stall/done/mdr=%b%b%b%b/%h expected 00 0 %b/%h",
               tag, dmem_read, dmem_write, stall_out, done_out, mdr_out, pend_done, model_mdr);
    end
    pend_done = 1'b0;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b1; ctrl_in = make_ctrl(OP_LDR, 16'h0000);
    addr_in = 16'h1234; wdata_in = 16'h5678; dmem_resp = 1'b0; dmem_rdata = 16'h0000;
    #1;
    checks++;
    if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, stall_out, done_out, mdr_out} !== 53'd0) begin
      errors++;
      $display("FAIL reset: rd=%b wr=%b addr=%h wd=%h be=%b stall=%b done=%b mdr=%h expected all 0",
               dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, stall_out, done_out, mdr_out);
    end
    #10;
    valid_in = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycle(1'b0, "post_reset");
  endtask

  task automatic test_ldr();
    run_op(make_ctrl(OP_LDR, 16'h1000), 1'b1, 16'h1000, 16'h0000, 16'hBEEF, 16'h0000, 3, 0, "ldr");
    idle_cycle(1'b0, "ldr_done");
  endtask

  task automatic test_stb();
    run_op(make_ctrl(OP_STB, 16'h2001), 1'b1, 16'h2001, 16'h4100, 16'hDEAD, 16'h0000, 1, 0, "stb");
    idle_cycle(1'b0, "stb_done");
  endtask

  task automatic test_ldi();
    run_op(make_ctrl(OP_LDI, 16'h3000), 1'b1, 16'h3000, 16'h0000, 16'h4000, 16'h0042, 2, 1, "ldi");
    idle_cycle(1'b0, "ldi_done");
  endtask

  task automatic test_sti();
    run_op(make_ctrl(OP_STI, 16'h3000), 1'b1, 16'h3000, 16'h1234, 16'h5000, 16'hFFFF, 1, 2, "sti");
    idle_cycle(1'b0, "sti_done");
  endtask

  task automatic test_nonmem();
    lc3b_control_word c;
    run_op(make_ctrl(OP_ADD, 16'h0000), 1'b1, 16'h1111, 16'h2222, 16'h0, 16'h0, 0, 0, "add");
    c = make_ctrl(OP_LDR, 16'h0000);
    c.is_nop = 1'b1;
    run_op(c, 1'b1, 16'h1000, 16'h0000, 16'h0, 16'h0, 0, 0, "nop_read");
    run_op(make_ctrl(OP_LDR, 16'h0000), 1'b0, 16'h1000, 16'h0000, 16'h0, 16'h0, 0, 0, "invalid_ldr");
    idle_cycle(1'b1, "stray_resp");
  endtask

  task automatic test_back_to_back();
    run_op(make_ctrl(OP_LDR, 16'h0100), 1'b1, 16'h0100, 16'h0000, 16'hA5A5, 16'h0, 0, 0, "b2b_ldr0");
    run_op(make_ctrl(OP_STR, 16'h0200), 1'b1, 16'h0200, 16'h7777, 16'h0, 16'h0, 0, 0, "b2b_str");
    run_op(make_ctrl(OP_LDI, 16'h0300), 1'b1, 16'h0300, 16'h0000, 16'h0400, 16'h1357, 0, 0, "b2b_ldi");
    run_op(make_ctrl(OP_STI, 16'h0500), 1'b1, 16'h0500, 16'h2468, 16'h0600, 16'h0, 1, 0, "b2b_sti");
    run_op(make_ctrl(OP_LDB, 16'h0701), 1'b1, 16'h0701, 16'h0000, 16'h00C3, 16'h0, 2, 0, "b2b_ldb");
    idle_cycle(1'b0, "b2b_done");
  endtask

  task automatic test_reset_mid();
    valid_in = 1'b1; ctrl_in = make_ctrl(OP_LDI, 16'h3000); addr_in = 16'h3000; wdata_in = 16'h0000;
    dmem_resp = 1'b1; dmem_rdata = 16'h4000;
    @(negedge clk);
    checks++;
    if ({dmem_read, dmem_address} !== {1'b1, 16'h3000}) begin
      errors++;
      $display("FAIL rstmid_ptr: rd=%b addr=%h expected rd=1 addr=3000", dmem_read, dmem_address);
    end
    exp_stall++;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    checks++;
    if ({dmem_read, dmem_address, stall_out} !== {1'b1, 16'h4000, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_data: rd=%b addr=%h stall=%b expected rd=1 addr=4000 stall=1",
               dmem_read, dmem_address, stall_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dmem_read, dmem_write, stall_out, done_out, mdr_out} !== 20'd0) begin
      errors++;
      $display("FAIL rstmid_abandon: rd=%b wr=%b stall=%b done=%b mdr=%h expected all 0",
               dmem_read, dmem_write, stall_out, done_out, mdr_out);
    end
    model_mdr = 16'h0000; pend_done = 1'b0; exp_stall = 0;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle(1'b1, "rstmid_stray0");
    idle_cycle(1'b1, "rstmid_stray1");
  endtask

  task automatic test_random();
    lc3b_opcode ops [9] = '{OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI, OP_ADD, OP_AND, OP_BR};
    lc3b_control_word c;
    logic [15:0] a;
    for (int i = 0; i < 80; i++) begin
      a = 16'($urandom);
      c = make_ctrl(ops[$urandom_range(0, 8)], a);
      c.is_nop = ($urandom_range(0, 7) == 0);
      run_op(c, ($urandom_range(0, 7) != 0), a, 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), "rand");
      if ($urandom_range(0, 1) == 0) idle_cycle(1'($urandom_range(0, 1)), "rand_gap");
    end
    idle_cycle(1'b0, "rand_end");
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_stb();
    test_ldi();
    test_sti();
    test_nonmem();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MEM_STALL_CNT_EN
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, exp_stall);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
